// File: rtl/axi_slave_package.sv
// Shared widths and the arbitration priority type for the requester recorder tag logic.
package axi_slave_package;
   localparam int REQUESTER_RECORDER_ADDR_WIDTH = 5;
   localparam int REQUESTER_RECORDER_WIDTH      = 32;

   typedef enum logic {
      PRIO_WR = 1'b0,
      PRIO_RD = 1'b1
   } prio_t;
endpackage

// File: rtl/tag_priority_encoder.sv
// Finds the lowest-index clear bit of the tag allocation bitmap.
module tag_priority_encoder
   import axi_slave_package::*;
#(
   parameter int TAG_W = REQUESTER_RECORDER_ADDR_WIDTH
) (
   input  logic [2**TAG_W-1:0] bitmap,
   output logic [TAG_W-1:0]    index,
   output logic                none_free
);

   // Scanning downward lets the last hit, the lowest free index, win.
   always_comb begin
      index     = '0;
      none_free = 1'b1;
      for (int i = 2**TAG_W-1; i >= 0; i--) begin
         if (!bitmap[i]) begin
            index     = TAG_W'(i);
            none_free = 1'b0;
         end
      end
   end

endmodule

// File: rtl/request_recorder_tag_ctrl.sv
// Tag allocator for AW/AR requesters: arbitrates, hands out the lowest free tag,
// writes the granted record into the recorder, and frees tags on completion.
module request_recorder_tag_ctrl
   import axi_slave_package::*;
#(
   parameter int TAG_W = REQUESTER_RECORDER_ADDR_WIDTH,
   parameter int REC_W = REQUESTER_RECORDER_WIDTH
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic             wr_req_valid,
   input  logic [REC_W-1:0] wr_req_data,
   output logic             wr_req_grant,
   input  logic             rd_req_valid,
   input  logic [REC_W-1:0] rd_req_data,
   output logic             rd_req_grant,
   output logic [TAG_W-1:0] req_tag,
   output logic             req_wr_en,
   output logic [TAG_W-1:0] req_wr_addr,
   output logic [REC_W-1:0] req_wr_data,
   input  logic             rel_valid,
   input  logic [TAG_W-1:0] rel_tag,
   output logic             rel_err,
   output logic [TAG_W:0]   tags_used,
   output logic             full,
   output logic             empty
);

   localparam int             NUM_TAGS = 2**TAG_W;
   localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(NUM_TAGS);

   logic [NUM_TAGS-1:0] bitmap_p1;
   logic [NUM_TAGS-1:0] bitmap_nxt;
   prio_t               prio_p1;
   logic [TAG_W-1:0]    free_idx;
   logic                none_free;
   logic                grant_ok;
   logic                wr_grant;
   logic                rd_grant;
   logic                any_grant;
   logic                rel_hit;
   logic                rel_miss;
   logic                both_req;
   logic [REC_W-1:0]    grant_data;

   tag_priority_encoder #(.TAG_W(TAG_W)) u_enc (
      .bitmap    (bitmap_p1),
      .index     (free_idx),
      .none_free (none_free)
   );

   always_comb begin
      grant_ok   = ARESETn && !full && !none_free;
      both_req   = wr_req_valid && rd_req_valid;
      wr_grant   = grant_ok && wr_req_valid && (!rd_req_valid || prio_p1 == PRIO_WR);
      rd_grant   = grant_ok && rd_req_valid && (!wr_req_valid || prio_p1 == PRIO_RD);
      any_grant  = wr_grant || rd_grant;
      rel_hit    = rel_valid && bitmap_p1[rel_tag];
      rel_miss   = rel_valid && !bitmap_p1[rel_tag];
      grant_data = wr_grant ? wr_req_data : rd_req_data;
      // A granted tag is always clear and a hit release always set, so the two never collide.
      bitmap_nxt = bitmap_p1;
      if (any_grant) bitmap_nxt[free_idx] = 1'b1;
      if (rel_hit)   bitmap_nxt[rel_tag]  = 1'b0;
   end

   assign wr_req_grant = wr_grant;
   assign rd_req_grant = rd_grant;
   assign req_tag      = free_idx;
   assign full         = (tags_used == FULL_CNT);
   assign empty        = (tags_used == '0);

   // ---- stage p1: allocation state and recorder write port ----
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         bitmap_p1   <= '0;
         tags_used   <= '0;
         prio_p1     <= PRIO_WR;
         req_wr_en   <= 1'b0;
         req_wr_addr <= '0;
         req_wr_data <= '0;
         rel_err     <= 1'b0;
      end else begin
         bitmap_p1 <= bitmap_nxt;
         rel_err   <= rel_miss;
         req_wr_en <= any_grant;
         if (any_grant) begin
            req_wr_addr <= free_idx;
            req_wr_data <= grant_data;
         end
         case ({any_grant, rel_hit})
            2'b10:   tags_used <= tags_used + (TAG_W+1)'(1);
            2'b01:   tags_used <= tags_used - (TAG_W+1)'(1);
            default: tags_used <= tags_used;
         endcase
         if (grant_ok && both_req)
            prio_p1 <= (prio_p1 == PRIO_WR) ? PRIO_RD : PRIO_WR;
      end
   end

endmodule

// File: tb/tb_request_recorder_tag_ctrl.sv
// Self-checking bench for request_recorder_tag_ctrl: directed table, corner sequences, random traffic.
module tb_request_recorder_tag_ctrl;
   import axi_slave_package::*;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic        wr_req_valid = 1'b0;
   logic [31:0] wr_req_data = '0;
   logic        wr_req_grant;
   logic        rd_req_valid = 1'b0;
   logic [31:0] rd_req_data = '0;
   logic        rd_req_grant;
   logic [4:0]  req_tag;
   logic        req_wr_en;
   logic [4:0]  req_wr_addr;
   logic [31:0] req_wr_data;
   logic        rel_valid = 1'b0;
   logic [4:0]  rel_tag = '0;
   logic        rel_err;
   logic [5:0]  tags_used;
   logic        full;
   logic        empty;

   request_recorder_tag_ctrl #(.TAG_W(5), .REC_W(32)) dut (
      .ACLK         (ACLK),
      .ARESETn      (ARESETn),
      .wr_req_valid (wr_req_valid),
      .wr_req_data  (wr_req_data),
      .wr_req_grant (wr_req_grant),
      .rd_req_valid (rd_req_valid),
      .rd_req_data  (rd_req_data),
      .rd_req_grant (rd_req_grant),
      .req_tag      (req_tag),
      .req_wr_en    (req_wr_en),
      .req_wr_addr  (req_wr_addr),
      .req_wr_data  (req_wr_data),
      .rel_valid    (rel_valid),
      .rel_tag      (rel_tag),
      .rel_err      (rel_err),
      .tags_used    (tags_used),
      .full         (full),
      .empty        (empty)
   );

   always #5 ACLK = ~ACLK;

   int errors = 0;
   int checks = 0;

   // reference model: set of in-flight tags, and who has priority
   bit [31:0]   m_bm;
   bit          m_pwr;
   bit          e_wen;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata;
   bit          e_relerr;

   // last sampled DUT values, for directed checks
   logic       a_wg, a_rg, a_wen, a_full;
   logic [4:0] a_tag, a_waddr;
   logic [5:0] a_used;

   typedef struct {
      bit         wv;
      bit         rv;
      bit         relv;
      logic [4:0] relt;
      bit         e_wg;
      bit         e_rg;
      logic [4:0] e_tag;
      int         e_used;
   } vec_t;
   vec_t tbl[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bm = '0; m_pwr = 1'b1; e_wen = 1'b0; e_waddr = '0; e_wdata = '0; e_relerr = 1'b0;
   endtask

   task automatic do_reset();
      ARESETn = 1'b0; wr_req_valid = 1'b1; rd_req_valid = 1'b1; rel_valid = 1'b0;
      @(negedge ACLK);
      chk("rst_wr_grant", wr_req_grant, 0);
      chk("rst_rd_grant", rd_req_grant, 0);
      @(posedge ACLK); #1;
      chk("rst_tags_used", tags_used, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_req_wr_en", req_wr_en, 0);
      chk("rst_req_wr_addr", req_wr_addr, 0);
      chk("rst_req_wr_data", req_wr_data, 0);
      chk("rst_rel_err", rel_err, 0);
      ARESETn = 1'b1; wr_req_valid = 1'b0; rd_req_valid = 1'b0;
      model_reset();
   endtask

   // One clock: drive, check combinational grant/tag mid-cycle, advance model, check registered outputs.
   task automatic cycle(input bit wv, input logic [31:0] wd, input bit rv, input logic [31:0] rd,
                        input bit relv, input logic [4:0] relt);
      int used, free_i;
      bit isfull, ewg, erg, rel_ok;
      bit [31:0] nb;
      wr_req_valid = wv; wr_req_data = wd; rd_req_valid = rv; rd_req_data = rd;
      rel_valid = relv; rel_tag = relt;
      used   = $countones(m_bm);
      isfull = (used == 32);
      free_i = 0;
      for (int i = 31; i >= 0; i--) if (!m_bm[i]) free_i = i;
      ewg = !isfull && wv && (!rv || m_pwr);
      erg = !isfull && rv && (!wv || !m_pwr);
      @(negedge ACLK);
      a_wg = wr_req_grant; a_rg = rd_req_grant; a_tag = req_tag;
      chk("wr_grant", a_wg, ewg);
      chk("rd_grant", a_rg, erg);
      if (ewg || erg) chk("req_tag", a_tag, free_i);
      nb     = m_bm;
      rel_ok = relv && m_bm[relt];
      e_wen  = ewg || erg;
      if (e_wen) begin
         nb[free_i] = 1'b1;
         e_waddr    = free_i[4:0];
         e_wdata    = ewg ? wd : rd;
      end
      if (rel_ok) nb[relt] = 1'b0;
      e_relerr = relv && !m_bm[relt];
      if (!isfull && wv && rv) m_pwr = !m_pwr;
      m_bm = nb;
      @(posedge ACLK); #1;
      a_wen = req_wr_en; a_waddr = req_wr_addr; a_used = tags_used; a_full = full;
      chk("req_wr_en", a_wen, e_wen);
      chk("req_wr_addr", a_waddr, e_waddr);
      chk("req_wr_data", req_wr_data, e_wdata);
      chk("rel_err", rel_err, e_relerr);
      chk("tags_used", a_used, $countones(m_bm));
      chk("full", a_full, $countones(m_bm) == 32);
      chk("empty", empty, m_bm == 0);
      wr_req_valid = 1'b0; rd_req_valid = 1'b0; rel_valid = 1'b0;
   endtask

   function automatic logic [4:0] pick_rel(input logic [4:0] start);
      logic [4:0] t;
      pick_rel = start;
      for (int k = 31; k >= 0; k--) begin
         t = start + 5'(k);
         if (m_bm[t]) pick_rel = t;
      end
   endfunction

   initial begin
      // from reset: both requesters contend, then releases interleave with grants
      tbl[0]  = '{1, 1, 0, 5'd0, 1, 0, 5'd0, 1};
      tbl[1]  = '{1, 1, 0, 5'd0, 0, 1, 5'd1, 2};
      tbl[2]  = '{1, 1, 0, 5'd0, 1, 0, 5'd2, 3};
      tbl[3]  = '{1, 1, 0, 5'd0, 0, 1, 5'd3, 4};
      tbl[4]  = '{0, 0, 1, 5'd1, 0, 0, 5'd0, 3};
      tbl[5]  = '{1, 0, 0, 5'd0, 1, 0, 5'd1, 4};
      tbl[6]  = '{0, 0, 1, 5'd9, 0, 0, 5'd0, 4};
      tbl[7]  = '{0, 1, 1, 5'd0, 0, 1, 5'd4, 4};
      tbl[8]  = '{1, 0, 0, 5'd0, 1, 0, 5'd0, 5};
      tbl[9]  = '{1, 0, 1, 5'd2, 1, 0, 5'd5, 5};
      tbl[10] = '{0, 1, 0, 5'd0, 0, 1, 5'd2, 6};

      model_reset();
      repeat (2) @(posedge ACLK);
      #1;
      do_reset();

      // single write request from reset
      cycle(1, 32'hA5A5_0001, 0, 32'h0, 0, 5'd0);
      chk("seq1_grant", a_wg, 1);
      chk("seq1_tag", a_tag, 0);
      chk("seq1_wen", a_wen, 1);
      chk("seq1_waddr", a_waddr, 0);
      chk("seq1_used", a_used, 1);

      do_reset();
      foreach (tbl[i]) begin
         cycle(tbl[i].wv, $urandom, tbl[i].rv, $urandom, tbl[i].relv, tbl[i].relt);
         chk($sformatf("tbl%0d_wg", i), a_wg, tbl[i].e_wg);
         chk($sformatf("tbl%0d_rg", i), a_rg, tbl[i].e_rg);
         if (tbl[i].e_wg || tbl[i].e_rg) chk($sformatf("tbl%0d_tag", i), a_tag, tbl[i].e_tag);
         chk($sformatf("tbl%0d_used", i), a_used, tbl[i].e_used);
      end

      // fill all tags, then refuse, then reuse a released tag
      do_reset();
      for (int i = 0; i < 32; i++) cycle(1, $urandom, 0, 0, 0, 5'd0);
      chk("fill_full", a_full, 1);
      cycle(1, $urandom, 1, $urandom, 0, 5'd0);
      chk("full_no_wg", a_wg, 0);
      chk("full_no_rg", a_rg, 0);
      cycle(0, 0, 0, 0, 1, 5'd7);
      chk("rel7_used", a_used, 31);
      cycle(1, $urandom, 0, 0, 0, 5'd0);
      chk("reuse7_grant", a_wg, 1);
      chk("reuse7_tag", a_tag, 7);
      chk("reuse7_full", a_full, 1);

      // release and request in the same full cycle: grant only on the next one
      cycle(0, 0, 1, $urandom, 1, 5'd3);
      chk("samecyc_no_grant", a_rg, 0);
      chk("samecyc_used", a_used, 31);
      cycle(0, 0, 1, $urandom, 0, 5'd0);
      chk("next_grant", a_rg, 1);
      chk("next_tag", a_tag, 3);
      chk("next_used", a_used, 32);

      // reset in the middle of a burst discards everything
      cycle(0, 0, 0, 0, 1, 5'd0);
      cycle(1, $urandom, 1, $urandom, 1, 5'd1);
      do_reset();

      // random traffic against the model
      for (int n = 0; n < 600; n++) begin
         bit wv, rv, relv;
         logic [4:0] relt;
         wv   = ($urandom_range(0, 99) < 55);
         rv   = ($urandom_range(0, 99) < 55);
         relv = ($urandom_range(0, 99) < 40);
         relt = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) != 0) relt = pick_rel(relt);
         cycle(wv, $urandom, rv, $urandom, relv, relt);
         if (n == 300) do_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
